// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR upstream sequencer.
package fir_pkg;

    localparam int NUM_TAPS = 8;   // taps / coefficients per load
    localparam int DATA_W   = 8;   // sample and coefficient width (signed)
    localparam int ADDR_W   = 3;   // coefficient address width
    localparam int ACC_W    = 32;  // datapath result width (signed)
    localparam int CNT_W    = 4;   // sample-history counter, saturates at NUM_TAPS

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_control_unit.sv
// Upstream sequencer for the 8-tap FIR datapath: loads the coefficient bank from a
// stream, then shifts samples into the delay line and registers each filter output.
//
// Handshakes: every stream transfers on a rising edge where valid and ready are both
// high in the preceding cycle; valid never depends on ready, and a producer holding
// valid keeps its data stable until the transfer.
module fir_control_unit
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load_req,
    input  logic                 i_coeff_valid,
    input  logic [DATA_W-1:0]    i_coeff_data,
    output logic                 o_coeff_ready,
    input  logic                 i_sample_valid,
    input  logic [DATA_W-1:0]    i_sample_data,
    output logic                 o_sample_ready,
    output logic                 o_coeff_write_en,
    output logic [ADDR_W-1:0]    o_coeff_addr,
    output logic [DATA_W-1:0]    o_coeff_data,
    output logic                 o_shift_enable,
    output logic [DATA_W-1:0]    o_dp_data,
    input  logic [ACC_W-1:0]     i_dp_result,
    output logic [ACC_W-1:0]     o_result,
    output logic                 o_result_valid,
    input  logic                 i_result_ready,
    output logic                 o_result_warm,
    output logic                 o_busy,
    output logic [1:0]           o_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_TAPS);

    fir_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [ACC_W-1:0]    result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                result_warm_q, result_warm_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;

    logic                coeff_accept;
    logic                sample_accept;
    logic                can_cap;
    logic                capture;

    // Handshake decode; coefficient writes only exist in LOAD and shifts only in RUN,
    // so the two datapath strobes can never coincide.
    always_comb begin
        can_cap        = !result_valid_q || i_result_ready;
        capture        = pending_q && can_cap;
        o_coeff_ready  = (state_q == ST_LOAD);
        coeff_accept   = o_coeff_ready && i_coeff_valid;
        o_sample_ready = (state_q == ST_RUN) && !i_load_req && (!pending_q || can_cap);
        sample_accept  = o_sample_ready && i_sample_valid;
    end

    // Datapath drive: strobes and their data are presented in the accepting cycle.
    always_comb begin
        o_coeff_write_en = coeff_accept;
        o_coeff_addr     = cnt_q;
        o_coeff_data     = coeff_accept ? i_coeff_data : '0;
        o_shift_enable   = sample_accept;
        o_dp_data        = sample_accept ? i_sample_data : '0;
    end

    // Next-state logic for the FSM, the address counter and the output slice.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        result_warm_d  = result_warm_q;
        sample_cnt_d   = sample_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_load_req) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (coeff_accept) begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_load_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait until the last shifted sample has been captured.
                if (!pending_q) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // The delay line is never cleared by a reload, so the history count only saturates.
        if (sample_accept) begin
            pending_d = 1'b1;
            if (sample_cnt_q != FULL_CNT) sample_cnt_d = sample_cnt_q + 1'b1;
        end else if (capture) begin
            pending_d = 1'b0;
        end

        // The count already includes the sample whose sum is being captured.
        if (capture) begin
            result_d       = i_dp_result;
            result_valid_d = 1'b1;
            result_warm_d  = (sample_cnt_q >= FULL_CNT);
        end else if (i_result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any partial load or pending sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_warm_q  <= 1'b0;
            sample_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_warm_q  <= result_warm_d;
            sample_cnt_q   <= sample_cnt_d;
        end
    end

    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_result_warm  = result_warm_q;
    assign o_busy         = (state_q != ST_RUN);
    assign o_state        = state_q;

endmodule
